// File: rtl/cdec8_board_pkg.sv
// Shared board-level constants for the CDEC8 DE0 front end.
//   BTN_*                    : bit positions of the push buttons in the
//                              button vector (clock, reset_N, p_clock).
//   N_BTN_DEFAULT            : number of board push buttons.
//   DEBOUNCE_CYCLES_DEFAULT  : stable cycles needed to accept a new button
//                              level; 1 ms at the 50 MHz DE0 oscillator.
package cdec8_board_pkg;

  localparam int unsigned BTN_CLOCK   = 2;
  localparam int unsigned BTN_RESET_N = 1;
  localparam int unsigned BTN_PCLOCK  = 0;

  localparam int unsigned N_BTN_DEFAULT           = 3;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 50000;

endpackage

// File: rtl/debounce_channel.sv
// One push-button conditioning channel: 2-FF synchronizer, debounce
// counter, registered debounced level and one-cycle press/release pulses.
//   clock         : system clock, rising edge
//   reset         : asynchronous, active-high
//   btn_n_in      : raw asynchronous button, active-low (pressed = 0)
//   btn_n_level   : debounced level, active-low, registered
//   press_pulse   : one cycle high when btn_n_level goes 1->0
//   release_pulse : one cycle high when btn_n_level goes 0->1
module debounce_channel
  import cdec8_board_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic btn_n_in,
  output logic btn_n_level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int unsigned    CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_1;
  logic             sync_2;
  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_1        <= 1'b1;
      sync_2        <= 1'b1;
      btn_n_level   <= 1'b1;
      count         <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      sync_1        <= btn_n_in;
      sync_2        <= sync_1;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      // Any sample agreeing with the current level discards accumulated
      // credit, so a glitch restarts the full stable-time requirement.
      if (sync_2 == btn_n_level) begin
        count <= '0;
      end else if (count == CNT_LAST) begin
        btn_n_level   <= sync_2;
        count         <= '0;
        press_pulse   <= ~sync_2;
        release_pulse <= sync_2;
      end else begin
        count <= count + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Front-end conditioning for the board push buttons {clock, reset_N,
// p_clock}; one independent debounce_channel per button.
//   clock         : system clock, rising edge
//   reset         : asynchronous, active-high
//   btn_n_in      : raw asynchronous buttons, active-low
//   btn_n_level   : debounced levels, active-low, registered
//   press_pulse   : per-bit one-cycle pulse on debounced 1->0
//   release_pulse : per-bit one-cycle pulse on debounced 0->1
module button_conditioner
  import cdec8_board_pkg::*;
#(
  parameter int unsigned N_BTN           = N_BTN_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_n_in,
  output logic [N_BTN-1:0] btn_n_level,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clock         (clock),
      .reset         (reset),
      .btn_n_in      (btn_n_in[i]),
      .btn_n_level   (btn_n_level[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] btn  = 3'b111;
  logic [2:0] lvl, prs, rel;
  logic [2:0] btn1 = 3'b111;
  logic [2:0] lvl1, prs1, rel1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  button_conditioner #(.N_BTN(3), .DEBOUNCE_CYCLES(4)) dut (
    .clock(clk), .reset(rst), .btn_n_in(btn),
    .btn_n_level(lvl), .press_pulse(prs), .release_pulse(rel)
  );

  button_conditioner #(.N_BTN(3), .DEBOUNCE_CYCLES(1)) dut1 (
    .clock(clk), .reset(rst), .btn_n_in(btn1),
    .btn_n_level(lvl1), .press_pulse(prs1), .release_pulse(rel1)
  );

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    #1;
    checks++;
    if (lvl !== 3'b111 || prs !== 3'b000 || rel !== 3'b000) begin
      errors++;
      $display("FAIL reset_init lvl=%b prs=%b rel=%b required 111/000/000", lvl, prs, rel);
    end
    step(2);
    rst = 1'b0;
    step(2);
    checks++;
    if (lvl !== 3'b111 || prs !== 3'b000 || rel !== 3'b000) begin
      errors++;
      $display("FAIL reset_idle lvl=%b prs=%b rel=%b required 111/000/000", lvl, prs, rel);
    end
  endtask

  task automatic test_clean_press;
    btn[0] = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      step(1);
      checks++;
      if (lvl !== ((c >= 6) ? 3'b110 : 3'b111) || prs !== ((c == 6) ? 3'b001 : 3'b000) || rel !== 3'b000) begin
        errors++;
        $display("FAIL clean_press c=%0d lvl=%b prs=%b rel=%b required lvl=%b prs=%b rel=000",
                 c, lvl, prs, rel, (c >= 6) ? 3'b110 : 3'b111, (c == 6) ? 3'b001 : 3'b000);
      end
    end
  endtask

  task automatic test_bounce;
    int np = 0;
    btn[2] = 1'b0;
    step(3);
    btn[2] = 1'b1;
    step(1);
    checks++;
    if (lvl[2] !== 1'b1 || prs[2] !== 1'b0) begin
      errors++;
      $display("FAIL bounce_glitch lvl2=%b prs2=%b required 1/0", lvl[2], prs[2]);
    end
    btn[2] = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      step(1);
      if (prs[2]) np++;
      checks++;
      if (lvl[2] !== (c < 6) || prs[2] !== (c == 6)) begin
        errors++;
        $display("FAIL bounce_settle c=%0d lvl2=%b prs2=%b required %b/%b", c, lvl[2], prs[2], c < 6, c == 6);
      end
    end
    checks++;
    if (np != 1 || lvl[0] !== 1'b0) begin
      errors++;
      $display("FAIL bounce_count pulses=%0d lvl0=%b required 1/0", np, lvl[0]);
    end
  endtask

  task automatic test_long_hold;
    int np = 0;
    int nr = 0;
    btn[1] = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      step(1);
      if (prs[1]) np++;
      if (rel[1]) nr++;
      if (c == 5 || c == 6) begin
        checks++;
        if (lvl[1] !== (c == 5)) begin
          errors++;
          $display("FAIL hold_level c=%0d lvl1=%b required %b", c, lvl[1], c == 5);
        end
      end
    end
    btn[1] = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step(1);
      if (prs[1]) np++;
      if (rel[1]) nr++;
      checks++;
      if (lvl[1] !== (c >= 6) || rel[1] !== (c == 6)) begin
        errors++;
        $display("FAIL release c=%0d lvl1=%b rel1=%b required %b/%b", c, lvl[1], rel[1], c >= 6, c == 6);
      end
    end
    checks++;
    if (np != 1 || nr != 1) begin
      errors++;
      $display("FAIL hold_counts press=%0d release=%0d required 1/1", np, nr);
    end
  endtask

  task automatic test_simultaneous;
    btn = 3'b111;
    step(10);
    checks++;
    if (lvl !== 3'b111) begin
      errors++;
      $display("FAIL sim_idle lvl=%b required 111", lvl);
    end
    btn = 3'b000;
    for (int c = 1; c <= 7; c++) begin
      step(1);
      checks++;
      if (prs !== ((c == 6) ? 3'b111 : 3'b000) || rel !== 3'b000 || lvl !== ((c >= 6) ? 3'b000 : 3'b111)) begin
        errors++;
        $display("FAIL simultaneous c=%0d lvl=%b prs=%b rel=%b", c, lvl, prs, rel);
      end
    end
  endtask

  task automatic test_async_reset;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (lvl !== 3'b111 || prs !== 3'b000 || rel !== 3'b000) begin
      errors++;
      $display("FAIL async_reset lvl=%b prs=%b rel=%b required 111/000/000", lvl, prs, rel);
    end
    step(3);
    checks++;
    if (lvl !== 3'b111 || prs !== 3'b000 || rel !== 3'b000) begin
      errors++;
      $display("FAIL reset_hold lvl=%b prs=%b rel=%b required 111/000/000", lvl, prs, rel);
    end
    btn = 3'b111;
    #2 rst = 1'b0;
    step(4);
  endtask

  task automatic test_reset_mid_count;
    btn[0] = 1'b0;
    step(4);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (lvl !== 3'b111 || prs !== 3'b000) begin
      errors++;
      $display("FAIL midcount_reset lvl=%b prs=%b required 111/000", lvl, prs);
    end
    step(1);
    #2 rst = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      step(1);
      checks++;
      if (lvl[0] !== (c < 6) || prs[0] !== (c == 6)) begin
        errors++;
        $display("FAIL midcount c=%0d lvl0=%b prs0=%b required %b/%b", c, lvl[0], prs[0], c < 6, c == 6);
      end
    end
  endtask

  task automatic test_deb1;
    btn1[0] = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      step(1);
      checks++;
      if (lvl1[0] !== (c < 3) || prs1[0] !== (c == 3)) begin
        errors++;
        $display("FAIL deb1_press c=%0d lvl=%b prs=%b required %b/%b", c, lvl1[0], prs1[0], c < 3, c == 3);
      end
    end
    btn1[1] = 1'b0;
    step(1);
    btn1[1] = 1'b1;
    for (int c = 2; c <= 6; c++) begin
      step(1);
      checks++;
      if (lvl1[1] !== (c != 3) || prs1[1] !== (c == 3) || rel1[1] !== (c == 4)) begin
        errors++;
        $display("FAIL deb1_glitch c=%0d lvl=%b prs=%b rel=%b required %b/%b/%b",
                 c, lvl1[1], prs1[1], rel1[1], c != 3, c == 3, c == 4);
      end
    end
    checks++;
    if (lvl1 !== 3'b110 || rel1[0] !== 1'b0) begin
      errors++;
      $display("FAIL deb1_final lvl=%b rel0=%b required 110/0", lvl1, rel1[0]);
    end
  endtask

  initial begin
    test_reset;
    test_clean_press;
    test_bounce;
    test_long_hold;
    test_simultaneous;
    test_async_reset;
    test_reset_mid_count;
    test_deb1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
